// File: rtl/memory_top.sv
// Scratch buffer (Depth x DataWidth) plus router FSM that streams an address
// range into a MaxWidth-byte sliding window for the PE array.
//
// state | meaning
// IDLE  | waiting for routeEn; window and finished hold
// READ  | presenting one address per cycle, N addresses total
// DRAIN | last byte returns from the buffer; finished is raised
// DONE  | holding result until routeEn drops
module memory_top #(
  parameter int MaxWidth  = 9,
  parameter int Depth     = 128,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          writeEn,
  input  logic [AddrWidth-1:0]          writeAddr,
  input  logic [DataWidth-1:0]          dataIn,
  input  logic                          routeEn,
  input  logic [AddrWidth-1:0]          startAddr,
  input  logic [AddrWidth-1:0]          finalAddr,
  output logic                          finished,
  output logic [MaxWidth*DataWidth-1:0] dataOut
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AddrWidth:0] FullCnt = (AddrWidth+1)'(Depth);

  logic [DataWidth-1:0]          r_mem [Depth];
  logic [DataWidth-1:0]          r_rd_data;
  logic                          r_rd_valid;
  logic [1:0]                    r_state;
  logic [AddrWidth-1:0]          r_ptr;
  logic [AddrWidth:0]            r_cnt;
  logic [MaxWidth*DataWidth-1:0] r_win;
  logic                          r_fin;
  logic [AddrWidth-1:0]          w_len;

  assign w_len    = finalAddr - startAddr;
  assign dataOut  = r_win;
  assign finished = r_fin;

  // Storage is never reset; a same-address read during a write sees old data.
  always_ff @(posedge clk) begin
    if (writeEn) r_mem[writeAddr] <= dataIn;
    r_rd_data <= r_mem[r_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_win      <= '0;
      r_fin      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_rd_valid)
        r_win <= {r_win[(MaxWidth-1)*DataWidth-1:0], r_rd_data};
      case (r_state)
        IDLE: begin
          if (routeEn) begin
            r_win   <= '0;
            r_ptr   <= startAddr;
            // A zero-length range means the whole buffer.
            r_cnt   <= (w_len == '0) ? FullCnt : {1'b0, w_len};
            r_state <= READ;
          end
        end
        READ: begin
          r_rd_valid <= 1'b1;
          r_ptr      <= r_ptr + 1'b1;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == (AddrWidth+1)'(1)) r_state <= DRAIN;
        end
        DRAIN: begin
          r_fin   <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (!routeEn) begin
            r_fin   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_top.sv
// Directed bench for memory_top: window contents and finished timing for
// exact, short, overflowing, wrapping, aborted and write-during-pass cases.
module tb_memory_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeEn;
  logic [6:0]  writeAddr;
  logic [7:0]  dataIn;
  logic        routeEn;
  logic [6:0]  startAddr;
  logic [6:0]  finalAddr;
  logic        finished;
  logic [71:0] dataOut;

  int vec = 0;
  int err = 0;

  memory_top dut (
    .clk(clk), .rst(rst), .writeEn(writeEn), .writeAddr(writeAddr),
    .dataIn(dataIn), .routeEn(routeEn), .startAddr(startAddr),
    .finalAddr(finalAddr), .finished(finished), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    writeEn = 1'b1; writeAddr = a; dataIn = d;
    tick();
    writeEn = 1'b0;
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) wr(7'(i), 8'(i + 1));
  endtask

  task automatic test_reset();
    rst = 1'b0; writeEn = 1'b0; writeAddr = '0; dataIn = '0;
    routeEn = 1'b0; startAddr = '0; finalAddr = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    vec++;
    if (finished !== 1'b0) begin err++; $display("FAIL reset_finished: got %b expected 0", finished); end
    vec++;
    if (dataOut !== 72'h0) begin err++; $display("FAIL reset_dataOut: got %h expected 0", dataOut); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (finished !== 1'b0) begin err++; $display("FAIL idle_no_finished: got %b expected 0 (cycle %0d)", finished, i); end
    end
  endtask

  // E0 is the first edge after routeEn is raised; finished expected at E0+n+1.
  task automatic run_pass(input logic [6:0] s, input logic [6:0] f, input int n,
                          input logic [71:0] exp, input bit drop, input string name);
    startAddr = s; finalAddr = f; routeEn = 1'b1;
    tick();
    if (drop) begin
      routeEn = 1'b0; startAddr = s + 7'd37; finalAddr = f + 7'd3;
    end
    for (int i = 1; i <= n; i++) tick();
    vec++;
    if (finished !== 1'b0) begin err++; $display("FAIL %s_early_finished: got %b expected 0", name, finished); end
    tick();
    vec++;
    if (finished !== 1'b1) begin err++; $display("FAIL %s_finished_rise: got %b expected 1", name, finished); end
    vec++;
    if (dataOut !== exp) begin err++; $display("FAIL %s_window: got %h expected %h", name, dataOut, exp); end
    if (!drop) begin
      tick();
      vec++;
      if (finished !== 1'b1) begin err++; $display("FAIL %s_finished_hold: got %b expected 1", name, finished); end
      routeEn = 1'b0;
    end
    tick();
    vec++;
    if (finished !== 1'b0) begin err++; $display("FAIL %s_finished_fall: got %b expected 0", name, finished); end
    vec++;
    if (dataOut !== exp) begin err++; $display("FAIL %s_window_retained: got %h expected %h", name, dataOut, exp); end
    startAddr = '0; finalAddr = '0;
  endtask

  task automatic test_exact_window();
    load_seq(9);
    run_pass(7'd0, 7'd9, 9, 72'h010203040506070809, 1'b0, "exact");
  endtask

  task automatic test_short_range();
    run_pass(7'd2, 7'd5, 3, 72'h000000000000030405, 1'b1, "short");
  endtask

  task automatic test_overflow();
    load_seq(12);
    run_pass(7'd0, 7'd12, 12, 72'h0405060708090A0B0C, 1'b0, "overflow");
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 128; i++) wr(7'(i), 8'(i));
    run_pass(7'd0, 7'd0, 128, 72'h7778797A7B7C7D7E7F, 1'b0, "wrap");
  endtask

  task automatic test_reset_mid_pass();
    load_seq(9);
    startAddr = 7'd0; finalAddr = 7'd9; routeEn = 1'b1;
    tick(); tick(); tick();
    vec++;
    if (dataOut !== 72'h01) begin err++; $display("FAIL abort_first_byte: got %h expected 01", dataOut); end
    rst = 1'b0;
    tick();
    vec++;
    if (finished !== 1'b0) begin err++; $display("FAIL abort_finished: got %b expected 0", finished); end
    vec++;
    if (dataOut !== 72'h0) begin err++; $display("FAIL abort_dataOut: got %h expected 0", dataOut); end
    rst = 1'b1; routeEn = 1'b0;
    tick();
    run_pass(7'd0, 7'd9, 9, 72'h010203040506070809, 1'b0, "rerun");
  endtask

  // mem[0] rewritten on the edge it is read (old data expected), mem[8] well ahead.
  task automatic test_write_during_pass();
    startAddr = 7'd0; finalAddr = 7'd9; routeEn = 1'b1;
    tick();
    writeEn = 1'b1; writeAddr = 7'd0; dataIn = 8'h55;
    tick();
    writeAddr = 7'd8; dataIn = 8'hAA;
    tick();
    writeEn = 1'b0;
    vec++;
    if (dataOut !== 72'h01) begin err++; $display("FAIL rdw_old_data: got %h expected 01", dataOut); end
    for (int i = 3; i <= 10; i++) tick();
    vec++;
    if (finished !== 1'b1) begin err++; $display("FAIL wdp_finished: got %b expected 1", finished); end
    vec++;
    if (dataOut !== 72'h0102030405060708AA) begin err++; $display("FAIL wdp_window: got %h expected 0102030405060708aa", dataOut); end
    routeEn = 1'b0;
    tick();
    run_pass(7'd0, 7'd1, 1, 72'h55, 1'b0, "rdw_after");
  endtask

  initial begin
    test_reset();
    test_exact_window();
    test_short_range();
    test_overflow();
    test_full_wrap();
    test_reset_mid_pass();
    test_write_during_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/memory_top.md
# memory_top

Scratch memory plus router for the DNN accelerator front end. It stores an 8-bit operand stream, such as a Toeplitz/im2col-expanded feature map, written one byte per cycle. On command it streams an address range out of the buffer into a 9-byte (3×3 kernel) sliding window for the downstream PE array. It consists of a 128×8 single-clock buffer and a sequencing router FSM.

## Interface
- MaxWidth, 9: window width in bytes (kernel taps).
- Depth, 128: buffer entries.
- DataWidth, 8: bits per entry.
- AddrWidth, $clog2(Depth) = 7: address width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- writeEn  in  1  write strobe; one byte per cycle.
- writeAddr  in  AddrWidth  write address.
- dataIn  in  DataWidth  write data.
- routeEn  in  1  level request to start a routing pass; must be held until finished.
- startAddr  in  AddrWidth  first address to route.
- finalAddr  in  AddrWidth  end address, exclusive.
- finished  out  1  pass complete; held while routeEn stays high.
- dataOut  out  MaxWidth*DataWidth  sliding window. Newest byte is in [7:0]; older bytes sit at higher byte lanes.

## Operation
- Buffer behaviour:
  - Synchronous write of mem[writeAddr] <= dataIn when writeEn=1, accepted in every FSM state.
  - Synchronous read, 1-cycle latency.
  - Read-during-write to the same address returns the old data.
  - Memory contents are not cleared by reset.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On an edge with routeEn=1, latch startAddr/finalAddr, clear dataOut to 0, load the read pointer with startAddr, and enter READ.
  - Length N = (finalAddr − startAddr) mod 128. N=0 means all 128 entries.
- READ:
  - Each cycle, present the pointer to the buffer and increment it mod 128, so the range wraps past 127 to 0.
  - After presenting the N-th address, enter DRAIN.
- Window shift: every returned byte shifts into dataOut as dataOut <= {dataOut[63:0], byte}. Bytes beyond 9 drop off the top.
- DRAIN: capture the last byte, set finished=1, and enter DONE.
- DONE:
  - Hold dataOut and finished.
  - routeEn=0 → finished=0 and return to IDLE. dataOut is retained.
- routeEn deasserted mid-pass is ignored; the pass always completes.
- startAddr/finalAddr changes after acceptance are ignored.

## Timing
- Reset: finished=0, dataOut=0, FSM=IDLE, read pointer=0.
- Let E0 be the acceptance edge.
  - The byte at start+k lands in dataOut[7:0] at edge E0+k+2, for k=0..N−1.
  - finished rises at edge E0+N+1, the same edge as the last byte.
- finished falls on the first edge where routeEn=0 is sampled in DONE.
- A new pass can be accepted no earlier than the edge after return to IDLE.
- Reset mid-pass aborts the pass: outputs go to reset values on the next edge, and memory is kept.
- Writes during a pass to not-yet-read addresses are visible to the pass if written at least 1 cycle before that address is presented.

## Test plan
- Reset check: hold rst=0 for 2 cycles, then release → finished=0, dataOut=72'h0, no spurious finished with routeEn=0.
- Exact window:
  - Stimulus: write 01..09 to addrs 0..8, then start=0, final=9, routeEn=1.
  - Required: dataOut=72'h010203040506070809; finished rises at E0+10 and stays high; dropping routeEn clears finished next edge.
- Short range: same memory, start=2, final=5 → dataOut=72'h000000000000030405, finished at E0+4.
- Overflowing range: write 01..0C to addrs 0..11, then start=0, final=12 → dataOut=72'h0405060708090A0B0C.
- Full wrap:
  - Stimulus: mem[a]=a for all 128 entries, start=final=0.
  - Required: 128 reads; dataOut=72'h7778797A7B7C7D7E7F; finished at E0+129.
- Reset mid-pass: assert rst=0 at E0+3 → finished=0 and dataOut=0 next edge. A rerun of the exact-window case afterwards gives the same result, proving memory was retained.
